// File: rtl/unary_add_pkg.sv
// Shared types and helpers for the unary adder.
package unary_add_pkg;

  // Controller phases: accumulate, emit pulse train, hold after completion.
  typedef enum logic [1:0] {
    ACC  = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Width of a counter covering 0..modulus-1.
  function automatic int unsigned cnt_w(input int unsigned modulus);
    return $clog2(modulus);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// Combinational population count of the unary input lanes.
//   din : NUM_IN lane bits
//   cnt : number of set bits, 0..NUM_IN
module unary_popcount #(
  parameter int unsigned NUM_IN = 2,
  localparam int unsigned PC_W  = $clog2(NUM_IN + 1)
) (
  input  logic [NUM_IN-1:0] din,
  output logic [PC_W-1:0]   cnt
);

  // Ripple sum of lane bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      cnt = cnt + PC_W'(din[i]);
    end
  end

endmodule

// File: rtl/unary_add_n.sv
// Unary pulse-count adder: accumulates set lane bits modulo MODULUS with a
// wrap strobe, and on request replays the count as a pulse train on dout
// followed by a one-cycle done strobe.
//   clk, rst  : clock, async active-high reset
//   en        : global enable (0 freezes state, forces strobes low)
//   clr       : synchronous clear, highest priority after rst
//   mode      : 0 accumulate, 1 emit
//   din       : unary lane bits
//   dout      : registered pulse train
//   carry     : registered wrap strobe
//   done      : registered emission-complete strobe
//   busy      : combinational, EMIT with nonzero count
//   count_o   : current accumulator value
module unary_add_n
  import unary_add_pkg::*;
#(
  parameter int unsigned NUM_IN  = 2,
  parameter int unsigned MODULUS = 14,
  localparam int unsigned CNT_W  = cnt_w(MODULUS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              mode,
  input  logic [NUM_IN-1:0] din,
  output logic              dout,
  output logic              carry,
  output logic              done,
  output logic              busy,
  output logic [CNT_W-1:0]  count_o
);

  localparam int unsigned PC_W  = $clog2(NUM_IN + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] MOD_X = SUM_W'(MODULUS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_d, carry_d, done_d;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;

  unary_popcount #(.NUM_IN(NUM_IN)) u_popcount (
    .din (din),
    .cnt (pop)
  );

  // One extra bit so the wrap test never sees a truncated sum.
  assign sum = SUM_W'(count_q) + SUM_W'(pop);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      count_q <= '0;
      dout    <= 1'b0;
      carry   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout    <= dout_d;
      carry   <= carry_d;
      done    <= done_d;
    end
  end

  // Next-state and next-output logic; strobes default low, state holds.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = 1'b0;
    carry_d = 1'b0;
    done_d  = 1'b0;
    if (clr) begin
      state_d = ACC;
      count_d = '0;
    end else if (en) begin
      if (!mode) begin
        state_d = ACC;
        if (sum >= MOD_X) begin
          count_d = CNT_W'(sum - MOD_X);
          carry_d = 1'b1;
        end else begin
          count_d = CNT_W'(sum);
        end
      end else begin
        unique case (state_q)
          ACC: begin
            state_d = EMIT;
            if (count_q != '0) begin
              dout_d  = 1'b1;
              count_d = count_q - CNT_W'(1);
            end
          end
          EMIT: begin
            if (count_q != '0) begin
              dout_d  = 1'b1;
              count_d = count_q - CNT_W'(1);
            end else begin
              done_d  = 1'b1;
              state_d = HOLD;
            end
          end
          HOLD: begin
            state_d = HOLD;
          end
          default: begin
            state_d = ACC;
          end
        endcase
      end
    end
  end

  assign busy    = (state_q == EMIT) && (count_q != '0);
  assign count_o = count_q;

endmodule

// File: tb/tb_unary_add_n.sv
// Self-checking bench for unary_add_n: directed vector table on a 2-lane
// mod-14 instance, hand sequences on a 3-lane mod-5 instance and async
// reset, then randomized traffic on both against a behavioural model.
module tb_unary_add_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: NUM_IN=2, MODULUS=14
  logic       en2, clr2, mode2;
  logic [1:0] din2;
  logic       dout2, carry2, done2, busy2;
  logic [3:0] cnt2;

  // Instance B: NUM_IN=3, MODULUS=5
  logic       en3, clr3, mode3;
  logic [2:0] din3;
  logic       dout3, carry3, done3, busy3;
  logic [2:0] cnt3;

  unary_add_n #(.NUM_IN(2), .MODULUS(14)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .clr(clr2), .mode(mode2), .din(din2),
    .dout(dout2), .carry(carry2), .done(done2), .busy(busy2), .count_o(cnt2)
  );

  unary_add_n #(.NUM_IN(3), .MODULUS(5)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .clr(clr3), .mode(mode3), .din(din3),
    .dout(dout3), .carry(carry3), .done(done3), .busy(busy3), .count_o(cnt3)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       clr, en, mode;
    logic [1:0] din;
    int         count;
    logic       carry, dout, done, busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic c, input logic e, input logic m, input logic [1:0] d,
                     input int cnt, input logic cy, input logic dv, input logic dn,
                     input logic b);
    vec_t v;
    v.clr = c; v.en = e; v.mode = m; v.din = d;
    v.count = cnt; v.carry = cy; v.dout = dv; v.done = dn; v.busy = b;
    tbl.push_back(v);
  endtask

  // Behavioural model: phase 0 accumulate, 1 emitting, 2 finished.
  task automatic model_step(input int m, input logic c, input logic e, input logic md,
                            input int pop, inout int v, inout int ph,
                            output logic d, output logic cy, output logic dn);
    d = 1'b0; cy = 1'b0; dn = 1'b0;
    if (c) begin
      v = 0; ph = 0;
    end else if (e) begin
      if (!md) begin
        cy = (v + pop >= m);
        v  = (v + pop) % m;
        ph = 0;
      end else if (ph == 0) begin
        ph = 1;
        if (v > 0) begin d = 1'b1; v = v - 1; end
      end else if (ph == 1) begin
        if (v > 0) begin d = 1'b1; v = v - 1; end
        else begin dn = 1'b1; ph = 2; end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int v2, ph2, v3, ph3;
  logic ed2, ec2, edn2, ed3, ec3, edn3;

  initial begin
    rst = 1'b1;
    en2 = 1'b0; clr2 = 1'b0; mode2 = 1'b0; din2 = '0;
    en3 = 1'b0; clr3 = 1'b0; mode3 = 1'b0; din3 = '0;
    #2;
    chk("rst_count", int'(cnt2), 0);
    chk("rst_dout", int'(dout2), 0);
    chk("rst_carry", int'(carry2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_busy", int'(busy2), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Accumulate to 13 then wrap on 13+1.
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 2'b11, 2 * i, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 13, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 0, 1, 0, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    // 12 + 2 wraps to 0.
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 2'b11, 2 * i, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 0, 1, 0, 0, 0);
    // 13 + 2 wraps to 1.
    for (int i = 1; i <= 6; i++) add(0, 1, 0, 2'b11, 2 * i, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 13, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 1, 1, 0, 0, 0);
    add(1, 1, 0, 2'b11, 0, 0, 0, 0, 0);
    // Emit 5.
    add(0, 1, 0, 2'b11, 2, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 4, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 5, 0, 0, 0, 0);
    add(0, 1, 1, 2'b11, 4, 0, 1, 0, 1);
    add(0, 1, 1, 2'b11, 3, 0, 1, 0, 1);
    add(0, 1, 1, 2'b11, 2, 0, 1, 0, 1);
    add(0, 1, 1, 2'b11, 1, 0, 1, 0, 1);
    add(0, 1, 1, 2'b11, 0, 0, 1, 0, 0);
    add(0, 1, 1, 2'b11, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2'b11, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b11, 0, 0, 0, 0, 0);
    // Emit 0: done on the second edge.
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 1, 0);
    add(0, 1, 1, 2'b00, 0, 0, 0, 0, 0);
    // Abort emission of 7 after 3 pulses, resume accumulating.
    add(0, 1, 0, 2'b11, 2, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 4, 0, 0, 0, 0);
    add(0, 1, 0, 2'b11, 6, 0, 0, 0, 0);
    add(0, 1, 0, 2'b01, 7, 0, 0, 0, 0);
    add(0, 1, 1, 2'b00, 6, 0, 1, 0, 1);
    add(0, 1, 1, 2'b00, 5, 0, 1, 0, 1);
    add(0, 1, 1, 2'b00, 4, 0, 1, 0, 1);
    add(0, 1, 0, 2'b01, 5, 0, 0, 0, 0);
    // Pause with en=0 mid-emission, then clr mid-emission.
    add(0, 1, 1, 2'b00, 4, 0, 1, 0, 1);
    add(0, 0, 1, 2'b00, 4, 0, 0, 0, 1);
    add(0, 0, 0, 2'b11, 4, 0, 0, 0, 1);
    add(0, 1, 1, 2'b00, 3, 0, 1, 0, 1);
    add(1, 0, 1, 2'b00, 0, 0, 0, 0, 0);
    add(0, 1, 0, 2'b00, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      clr2 = tbl[i].clr; en2 = tbl[i].en; mode2 = tbl[i].mode; din2 = tbl[i].din;
      tick();
      chk($sformatf("tbl%0d_count", i), int'(cnt2), tbl[i].count);
      chk($sformatf("tbl%0d_carry", i), int'(carry2), int'(tbl[i].carry));
      chk($sformatf("tbl%0d_dout", i), int'(dout2), int'(tbl[i].dout));
      chk($sformatf("tbl%0d_done", i), int'(done2), int'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), int'(busy2), int'(tbl[i].busy));
    end

    // 3-lane mod-5: 0+3=3, 3+3=6 wraps to 1.
    en3 = 1'b1; din3 = 3'b111;
    tick();
    chk("m5_first_count", int'(cnt3), 3);
    chk("m5_first_carry", int'(carry3), 0);
    tick();
    chk("m5_second_count", int'(cnt3), 1);
    chk("m5_second_carry", int'(carry3), 1);
    din3 = 3'b000;
    tick();
    chk("m5_carry_clears", int'(carry3), 0);

    // Async reset in the middle of an emission.
    en2 = 1'b1; mode2 = 1'b0; din2 = 2'b11;
    tick();
    tick();
    mode2 = 1'b1;
    tick();
    chk("pre_rst_dout", int'(dout2), 1);
    chk("pre_rst_count", int'(cnt2), 3);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_dout", int'(dout2), 0);
    chk("arst_count", int'(cnt2), 0);
    chk("arst_busy", int'(busy2), 0);
    chk("arst_count3", int'(cnt3), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic on both instances.
    v2 = 0; ph2 = 0; v3 = 0; ph3 = 0;
    mode2 = 1'b0; mode3 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      clr2 = ($urandom_range(0, 39) == 0);
      en2  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode2 = ~mode2;
      din2 = 2'($urandom);
      clr3 = ($urandom_range(0, 39) == 0);
      en3  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode3 = ~mode3;
      din3 = 3'($urandom);
      model_step(14, clr2, en2, mode2, $countones(din2), v2, ph2, ed2, ec2, edn2);
      model_step(5, clr3, en3, mode3, $countones(din3), v3, ph3, ed3, ec3, edn3);
      tick();
      chk("rnd2_count", int'(cnt2), v2);
      chk("rnd2_dout", int'(dout2), int'(ed2));
      chk("rnd2_carry", int'(carry2), int'(ec2));
      chk("rnd2_done", int'(done2), int'(edn2));
      chk("rnd2_busy", int'(busy2), int'(ph2 == 1 && v2 != 0));
      chk("rnd3_count", int'(cnt3), v3);
      chk("rnd3_dout", int'(dout3), int'(ed3));
      chk("rnd3_carry", int'(carry3), int'(ec3));
      chk("rnd3_done", int'(done3), int'(edn3));
      chk("rnd3_busy", int'(busy3), int'(ph3 == 1 && v3 != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/unary_add_n.md
Name: unary_add_n

Overview:
Parametrised unary (pulse-count) adder for the unary arithmetic datapath. Accumulates the number of asserted bits across NUM_IN serial unary lanes modulo MODULUS and raises a one-cycle carry on each wrap. On request it replays the accumulated value as a unary pulse train on dout, followed by a completion strobe. Successor to the fixed 2-lane, mod-14 adder; adds lane count, modulus, a clear, an emit handshake and mid-operation abort.

Parameters:
NUM_IN, 2, number of unary input lanes; legal 1..MODULUS
MODULUS, 14, accumulator modulus; count range 0..MODULUS-1; legal >= 2
CNT_W, $clog2(MODULUS), derived count width; not overridden

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  global enable; 0 freezes all state
clr  in  1  synchronous clear; priority over en and mode
mode  in  1  0 = accumulate, 1 = emit
din  in  NUM_IN  unary lane bits, sampled when en=1 and mode=0
dout  out  1  unary output pulse train
carry  out  1  one-cycle wrap strobe
done  out  1  one-cycle emission-complete strobe
busy  out  1  high while in EMIT with count != 0
count_o  out  CNT_W  current accumulator value

Behaviour:
- Reset (rst=1, async): count=0, state=ACC, dout=0, carry=0, done=0. busy=0 and count_o=0 follow.
- All outputs are registered except busy (combinational: state==EMIT && count!=0) and count_o (= count).
- States: ACC, EMIT, HOLD.
- Priority each edge: rst > clr > !en > mode.
- clr=1: count=0, state=ACC, dout/carry/done=0, regardless of en.
- en=0: count and state hold; dout, carry and done forced to 0.
- mode=0 (any state): state goes to ACC; dout=0, done=0.
  - s = popcount(din), range 0..NUM_IN; sum = count + s, computed CNT_W+1 wide (no truncation).
  - If sum >= MODULUS: count = sum - MODULUS and carry=1. Otherwise count = sum and carry=0.
  - Latency 1: carry is high in the cycle after the sampling edge. Never two wraps in one cycle, guaranteed by NUM_IN <= MODULUS.
- mode=1, state ACC: go to EMIT; carry=0. If count!=0, dout=1 and count decrements; else dout=0.
- mode=1, state EMIT:
  - count!=0: dout=1, count decrements.
  - count==0: dout=0, done=1, go to HOLD.
- mode=1, state HOLD: dout=0, done=0, count holds (0). Stays until mode=0 or clr.
- Emission timing: value N gives dout high for exactly N consecutive enabled cycles starting on the first mode=1 edge. done follows on the next enabled edge after the last pulse. For N=0, done comes 2 edges after mode rises.
- Abort: mode dropping to 0 mid-EMIT stops pulses immediately, with no done. The remaining count is retained and resumes accumulating.
- en=0 mid-EMIT pauses the train (dout=0) without losing count; it resumes when en returns.
- carry is always 0 outside accumulate cycles; done is never asserted in ACC.

Decomposition:
- Package unary_add_pkg: state enum (ACC, EMIT, HOLD) and a localparam function for CNT_W.
- Sub-module unary_popcount (parameter NUM_IN; din in, combinational count out, width $clog2(NUM_IN+1)).
- Everything else lives in the top.

Test Plan:
- NUM_IN=2, MODULUS=14, reset then din=2'b11 for 6 cycles, din=2'b01 once -> count_o=13, carry never high; next din=2'b01 -> count_o=0, carry=1 for one cycle.
- Same config, count=12, din=2'b11 -> count_o=0, carry=1. With count=13, din=2'b11 -> count_o=1, carry=1.
- count=5, mode=1 held -> dout high exactly 5 cycles, busy high during the first 4, done=1 the following cycle, then HOLD with dout=0 and done=0.
- count=0, mode=1 -> dout stays 0, done pulses on the 2nd edge.
- count=7, mode=1 for 3 cycles then mode=0 with din=2'b01 -> 3 pulses, no done, count_o 4 then 5.
- NUM_IN=3, MODULUS=5: din=3'b111 twice -> count_o 3 then 1, carry on the second. Also: clr mid-EMIT -> count_o=0, dout=0 next cycle. Also: rst asserted mid-cycle -> outputs 0 immediately, no clock required.
